nl_tile_inject: RTL and testbench

NL_TILE_INJECT -- requirements
Module: nl_tile_inject

---
 rtl/nl_tile_inject.sv | 129 ++++++++++++
 tb/tb_nl_tile_inject.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nl_tile_inject.sv
// Packet-to-flit injector for a router TILE port: turns a request plus payload words
// into head/body/tail flits. Sending is credit-gated against the downstream VC buffer.
module nl_tile_inject #(
  parameter int BUF_LEN = 4,
  parameter int DW      = 32,
  parameter int XW      = 4,
  parameter int YW      = 4,
  parameter int LW      = 4,
  localparam int CW     = $clog2(BUF_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [XW-1:0] req_dest_x,
  input  logic [YW-1:0] req_dest_y,
  input  logic [LW-1:0] req_len,
  input  logic          pld_valid,
  output logic          pld_ready,
  input  logic [DW-1:0] pld_data,
  output logic          flit_valid,
  output logic          flit_head,
  output logic          flit_tail,
  output logic [DW-1:0] flit_data,
  input  logic          credit_valid,
  output logic [CW-1:0] credits,
  output logic          credit_err,
  output logic [15:0]   pkt_count,
  output logic          o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // Ready never depends on valid, and a flit leaves exactly one cycle after its handshake.
  typedef enum logic {IDLE = 1'b0, BODY = 1'b1} state_t;

  state_t        r_state, w_state_nxt;
  logic [LW-1:0] r_remaining, w_remaining_nxt;
  logic [CW-1:0] r_credits;
  logic          r_credit_err;
  logic [15:0]   r_pkt_count;
  logic          r_flit_valid, r_flit_head, r_flit_tail;
  logic [DW-1:0] r_flit_data;

  logic          w_has_credit, w_req_hs, w_pld_hs, w_send, w_tail;
  logic [DW-1:0] w_head_data, w_flit_data_nxt;

  assign w_has_credit = (r_credits != '0);
  assign req_ready    = (r_state == IDLE) && w_has_credit;
  assign pld_ready    = (r_state == BODY) && w_has_credit;
  assign w_req_hs     = req_valid & req_ready;
  assign w_pld_hs     = pld_valid & pld_ready;
  assign w_send       = w_req_hs | w_pld_hs;

  always_comb begin
    w_head_data = '0;
    w_head_data[XW-1:0]              = req_dest_x;
    w_head_data[XW+YW-1:XW]          = req_dest_y;
    w_head_data[XW+YW+LW-1:XW+YW]    = req_len;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_tail          = 1'b0;
    w_flit_data_nxt = w_head_data;
    case (r_state)
      IDLE: begin
        if (w_req_hs) begin
          // A zero-length packet is a single head+tail flit.
          if (req_len == '0) begin
            w_tail = 1'b1;
          end else begin
            w_state_nxt     = BODY;
            w_remaining_nxt = req_len;
          end
        end
      end
      BODY: begin
        w_flit_data_nxt = pld_data;
        if (w_pld_hs) begin
          w_remaining_nxt = r_remaining - LW'(1);
          if (r_remaining == LW'(1)) begin
            w_tail      = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_remaining  <= '0;
      r_credits    <= CW'(BUF_LEN);
      r_credit_err <= 1'b0;
      r_pkt_count  <= '0;
      r_flit_valid <= 1'b0;
      r_flit_head  <= 1'b0;
      r_flit_tail  <= 1'b0;
      r_flit_data  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_remaining  <= w_remaining_nxt;
      r_flit_valid <= w_send;
      r_flit_head  <= w_req_hs;
      r_flit_tail  <= w_tail;
      if (w_send) r_flit_data <= w_flit_data_nxt;
      // A returned credit in the same cycle as a send cancels out.
      if (w_send && !credit_valid) begin
        r_credits <= r_credits - CW'(1);
      end else if (credit_valid && !w_send) begin
        if (r_credits == CW'(BUF_LEN)) r_credit_err <= 1'b1;
        else                           r_credits    <= r_credits + CW'(1);
      end
      if (w_tail) r_pkt_count <= r_pkt_count + 16'd1;
    end
  end

  assign flit_valid  = r_flit_valid;
  assign flit_head   = r_flit_head;
  assign flit_tail   = r_flit_tail;
  assign flit_data   = r_flit_data;
  assign credits     = r_credits;
  assign credit_err  = r_credit_err;
  assign pkt_count   = r_pkt_count;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_nl_tile_inject.sv
// Directed bench for nl_tile_inject: a reference model of credits/packet count and an
// expected-flit queue filled at each handshake and drained as flits appear.
module tb_nl_tile_inject;
  localparam int BUF_LEN = 4;
  localparam int DW = 32;
  localparam int CW = $clog2(BUF_LEN + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready;
  logic [3:0]    req_dest_x, req_dest_y, req_len;
  logic          pld_valid, pld_ready;
  logic [DW-1:0] pld_data;
  logic          flit_valid, flit_head, flit_tail;
  logic [DW-1:0] flit_data;
  logic          credit_valid;
  logic [CW-1:0] credits;
  logic          credit_err;
  logic [15:0]   pkt_count;
  logic          o_dbg_state;

  int n_asserts = 0;
  int n_fail    = 0;

  // expected flit = {head, tail, data}
  logic [DW+1:0] exp_q[$];
  logic [DW+1:0] m_exp;
  int            m_credits;
  logic          m_err;
  logic [15:0]   m_pkt;
  logic          m_state;
  logic [3:0]    m_rem;

  nl_tile_inject #(.BUF_LEN(BUF_LEN), .DW(DW), .XW(4), .YW(4), .LW(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dest_x(req_dest_x), .req_dest_y(req_dest_y), .req_len(req_len),
    .pld_valid(pld_valid), .pld_ready(pld_ready), .pld_data(pld_data),
    .flit_valid(flit_valid), .flit_head(flit_head), .flit_tail(flit_tail),
    .flit_data(flit_data),
    .credit_valid(credit_valid), .credits(credits), .credit_err(credit_err),
    .pkt_count(pkt_count), .o_dbg_state(o_dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every flit seen must match the head of the expected queue
  always @(negedge clk) begin
    if (flit_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("flit_unexpected", {63'd0, flit_valid}, 64'd0);
      end else begin
        m_exp = exp_q.pop_front();
        chk("flit", {30'd0, flit_head, flit_tail, flit_data}, {30'd0, m_exp});
      end
    end
  end

  task automatic cv_model();
    if (credit_valid) begin
      if (m_credits == BUF_LEN) m_err = 1'b1;
      else m_credits++;
    end
  endtask

  // driver tasks: all start and end 1 time unit after a rising edge
  task automatic send_req(input logic [3:0] x, input logic [3:0] y, input logic [3:0] l,
                          input bit with_cv);
    int n = 0;
    req_valid = 1'b1; req_dest_x = x; req_dest_y = y; req_len = l;
    credit_valid = with_cv;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 50) begin cv_model(); @(negedge clk); n++; end
    chk("req_accept", {63'd0, req_ready}, 64'd1);
    if (req_ready === 1'b1) begin
      exp_q.push_back({1'b1, (l == 4'd0), 20'd0, l, y, x});
      if (!with_cv) m_credits--;
      if (l == 4'd0) m_pkt++;
      else begin m_state = 1'b1; m_rem = l; end
    end
    @(posedge clk); #1;
    req_valid = 1'b0; credit_valid = 1'b0;
  endtask

  task automatic send_pld(input logic [DW-1:0] d);
    int n = 0;
    logic tl;
    pld_valid = 1'b1; pld_data = d;
    @(negedge clk);
    while (pld_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("pld_accept", {63'd0, pld_ready}, 64'd1);
    if (pld_ready === 1'b1) begin
      tl = (m_rem == 4'd1);
      exp_q.push_back({1'b0, tl, d});
      m_rem--;
      m_credits--;
      if (tl) begin m_pkt++; m_state = 1'b0; end
    end
    @(posedge clk); #1;
    pld_valid = 1'b0;
  endtask

  task automatic credit_pulse();
    credit_valid = 1'b1;
    @(negedge clk);
    cv_model();
    @(posedge clk); #1;
    credit_valid = 1'b0;
  endtask

  // drive valids that must be refused for n cycles
  task automatic hold_check(input int n, input bit dp, input bit dr);
    pld_valid = dp; req_valid = dr; pld_data = 32'hDEAD_BEEF;
    req_dest_x = 4'hF; req_dest_y = 4'hF; req_len = 4'h1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (dp) chk("pld_refused", {63'd0, pld_ready}, 64'd0);
      if (dr) chk("req_refused", {63'd0, req_ready}, 64'd0);
    end
    @(posedge clk); #1;
    pld_valid = 1'b0; req_valid = 1'b0;
  endtask

  task automatic chk_model(input string tag);
    @(negedge clk);
    chk({tag, "_credits"}, 64'(credits), 64'(m_credits));
    chk({tag, "_err"}, {63'd0, credit_err}, {63'd0, m_err});
    chk({tag, "_pkt"}, {48'd0, pkt_count}, {48'd0, m_pkt});
    chk({tag, "_state"}, {63'd0, o_dbg_state}, {63'd0, m_state});
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_fv"}, {63'd0, flit_valid}, 64'd0);
    chk({tag, "_fh"}, {63'd0, flit_head}, 64'd0);
    chk({tag, "_ft"}, {63'd0, flit_tail}, 64'd0);
    chk({tag, "_fd"}, 64'(flit_data), 64'd0);
    chk({tag, "_credits"}, 64'(credits), 64'(BUF_LEN));
    chk({tag, "_err"}, {63'd0, credit_err}, 64'd0);
    chk({tag, "_pkt"}, {48'd0, pkt_count}, 64'd0);
    chk({tag, "_state"}, {63'd0, o_dbg_state}, 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    m_credits = BUF_LEN; m_err = 1'b0; m_pkt = '0; m_state = 1'b0; m_rem = '0;
  endtask

  initial begin
    int n_loop;
    rst = 1'b1;
    req_valid = 0; req_dest_x = 0; req_dest_y = 0; req_len = 0;
    pld_valid = 0; pld_data = 0; credit_valid = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    // basic packet: head, body 0xA, tail 0xB
    send_req(4'd3, 4'd5, 4'd2, 1'b0);
    hold_check(2, 1'b0, 1'b1);
    send_pld(32'hA);
    send_pld(32'hB);
    chk_model("len2");
    repeat (3) credit_pulse();
    chk_model("len2_ret");

    // zero-length packet, then payload ignored in IDLE
    send_req(4'd7, 4'd2, 4'd0, 1'b0);
    chk_model("len0");
    hold_check(2, 1'b1, 1'b0);
    credit_pulse();

    // credit starvation mid-packet
    send_req(4'd1, 4'd1, 4'd6, 1'b0);
    send_pld(32'h1);
    send_pld(32'h2);
    send_pld(32'h3);
    chk_model("starved");
    hold_check(3, 1'b1, 1'b1);
    credit_pulse();
    send_pld(32'h4);
    hold_check(2, 1'b1, 1'b0);
    repeat (4) credit_pulse();
    send_pld(32'h5);
    send_pld(32'h6);
    chk_model("len6_done");

    // simultaneous send and credit return at credits=2, then overflow
    send_req(4'd2, 4'd3, 4'd0, 1'b1);
    chk_model("simul");
    repeat (2) credit_pulse();
    credit_pulse();
    chk_model("overflow");
    credit_pulse();
    send_req(4'd9, 4'd9, 4'd0, 1'b0);
    chk_model("err_sticky");
    credit_pulse();

    // reset mid-packet
    send_req(4'd4, 4'd4, 4'd3, 1'b0);
    send_pld(32'h11);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk_reset_outputs("midrst");
    send_req(4'd6, 4'd1, 4'd1, 1'b0);
    send_pld(32'h55);
    chk_model("post_rst");
    credit_pulse();
    credit_pulse();

    // bulk len=0 packets with credits returned each cycle, up to 0xFFFF
    n_loop = 32'hFFFF - int'(m_pkt);
    req_valid = 1'b1; req_dest_x = 0; req_dest_y = 0; req_len = 0; credit_valid = 1'b1;
    for (int i = 0; i < n_loop; i++) begin
      @(negedge clk);
      chk("bulk_ready", {63'd0, req_ready}, 64'd1);
      if (req_ready === 1'b1) begin
        exp_q.push_back({2'b11, 32'd0});
        m_pkt++;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0; credit_valid = 1'b0;
    chk_model("preload");
    send_req(4'd0, 4'd0, 4'd0, 1'b0);
    chk_model("wrap");
    credit_pulse();
    chk_model("final");

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
